// File: rtl/dc_scan_driver_pkg.sv
// Shared types and defaults for the digital-core scan driver.
// Holds the FSM state enum and counter-width helpers.
package dc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } dc_state_e;

  localparam int DC_CHAIN_LEN = 3;
  localparam int DC_DATA_W    = 8;
  localparam int DC_DIV       = 4;

  // Strobe counter must reach N without wrapping.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int div_w(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/dc_scan_driver_if.sv
// Host-side handshake bundle of the scan driver.
// master: command logic; slave: dc_scan_driver.
interface dc_scan_driver_if
  import dc_pkg::*;
#(
  parameter int DATA_W = DC_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              abort;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data, tx_valid, abort,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid, abort,
    output tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/dc_enable_gen.sv
// Strobe divider: registered tick every DIV cycles while run.
// Ports: internal_clk, dc_rstn, clr (first tick next cycle), run, tick.
module dc_enable_gen
  import dc_pkg::*;
#(
  parameter int DIV = DC_DIV
) (
  input  logic internal_clk,
  input  logic dc_rstn,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int W = div_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge internal_clk or negedge dc_rstn) begin
    if (!dc_rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else if (run) begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == LAST);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dc_scan_driver.sv
// Shifts a word MSB-first into the core scan chain and returns
// the word emerging at the far end. Ports: clk/rst, bus, dc_*.
module dc_scan_driver
  import dc_pkg::*;
#(
  parameter int   DATA_W    = DC_DATA_W,
  parameter int   CHAIN_LEN = DC_CHAIN_LEN,
  parameter int   DIV       = DC_DIV,
  parameter logic PAD_VAL   = 1'b0
) (
  input  logic             internal_clk,
  input  logic             dc_rstn,
  dc_scan_driver_if.slave  bus,
  output logic             dc_clk_enable,
  output logic             dc_digital_input,
  input  logic             dc_digital_output
);

  localparam int N  = DATA_W + CHAIN_LEN;
  localparam int SW = cnt_w(N);
  localparam logic [SW-1:0] S_LAST = SW'(N - 1);
  localparam logic [SW-1:0] S_CAP  = SW'(CHAIN_LEN);

  dc_state_e         state;
  logic [SW-1:0]     scnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_nxt;
  logic [DATA_W-1:0] rx_nxt;
  logic              accept;
  logic              abt;
  logic              stb;
  logic              last;
  logic              run;

  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state == SHIFT);

  assign accept = (state == IDLE) & bus.tx_valid & ~bus.abort;
  assign abt    = (state == SHIFT) & bus.abort;
  assign stb    = (state == SHIFT) & dc_clk_enable & ~bus.abort;
  assign last   = dc_clk_enable & (scnt == S_LAST);
  // Stop the divider on the edge that ends the run, so no
  // stray strobe is registered after the last one.
  assign run    = (state == SHIFT) & ~bus.abort & ~last;

  // Pad bits enter at the LSB and surface once data is spent.
  assign tx_nxt = (tx_sh << 1) | DATA_W'(PAD_VAL);
  assign rx_nxt = (rx_sh << 1) | DATA_W'(dc_digital_output);

  dc_enable_gen #(
    .DIV (DIV)
  ) u_en (
    .internal_clk (internal_clk),
    .dc_rstn      (dc_rstn),
    .clr          (accept),
    .run          (run),
    .tick         (dc_clk_enable)
  );

  always_ff @(posedge internal_clk or negedge dc_rstn) begin
    if (!dc_rstn) begin
      state            <= IDLE;
      scnt             <= '0;
      tx_sh            <= '0;
      rx_sh            <= '0;
      dc_digital_input <= 1'b0;
      bus.rx_data      <= '0;
      bus.rx_valid     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      unique case (1'b1)
        accept: begin
          state            <= SHIFT;
          scnt             <= '0;
          tx_sh            <= bus.tx_data;
          rx_sh            <= '0;
          dc_digital_input <= bus.tx_data[DATA_W-1];
        end
        abt: begin
          state <= IDLE;
        end
        stb: begin
          tx_sh            <= tx_nxt;
          dc_digital_input <= tx_nxt[DATA_W-1];
          scnt             <= scnt + 1'b1;
          // Early strobes return stale chain contents.
          if (scnt >= S_CAP) rx_sh <= rx_nxt;
          if (last) begin
            state        <= IDLE;
            bus.rx_data  <= rx_nxt;
            bus.rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_scan_driver.sv
// Randomized bench for dc_scan_driver against a scan chain model.
// Two instances: DIV=4 and DIV=1, both DATA_W=8, CHAIN_LEN=3.
module tb_dc_scan_driver;
  import dc_pkg::*;

  localparam int DW = 8;
  localparam int CL = 3;
  localparam int N  = DW + CL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  dc_scan_driver_if #(.DATA_W(DW)) ba ();
  dc_scan_driver_if #(.DATA_W(DW)) bb ();

  logic en_a, din_a, dout_a;
  logic en_b, din_b, dout_b;
  logic [CL-1:0] ch_a, ch_b;
  logic pre_req = 1'b0;
  logic [CL-1:0] pre_val = '0;

  assign dout_a = ch_a[CL-1];
  assign dout_b = ch_b[CL-1];

  // Ideal scan chain: shifts din in on each enable strobe.
  always @(posedge clk) begin
    if (pre_req) begin
      ch_a <= pre_val;
      ch_b <= pre_val;
    end else begin
      if (en_a) ch_a <= {ch_a[CL-2:0], din_a};
      if (en_b) ch_b <= {ch_b[CL-2:0], din_b};
    end
  end

  dc_scan_driver #(
    .DATA_W(DW), .CHAIN_LEN(CL), .DIV(4), .PAD_VAL(1'b0)
  ) u_a (
    .internal_clk      (clk),
    .dc_rstn           (rst_n),
    .bus               (ba.slave),
    .dc_clk_enable     (en_a),
    .dc_digital_input  (din_a),
    .dc_digital_output (dout_a)
  );

  dc_scan_driver #(
    .DATA_W(DW), .CHAIN_LEN(CL), .DIV(1), .PAD_VAL(1'b0)
  ) u_b (
    .internal_clk      (clk),
    .dc_rstn           (rst_n),
    .bus               (bb.slave),
    .dc_clk_enable     (en_b),
    .dc_digital_input  (din_b),
    .dc_digital_output (dout_b)
  );

  int            sa_c[$];
  logic          sa_b[$];
  logic          sa_o[$];
  int            ra_c[$];
  logic [DW-1:0] ra_d[$];
  int            sb_c[$];
  logic          sb_b[$];
  int            rb_c[$];
  logic [DW-1:0] rb_d[$];

  always @(negedge clk) begin
    if (en_a === 1'b1) begin
      sa_c.push_back(cyc);
      sa_b.push_back(din_a);
      sa_o.push_back(dout_a);
    end
    if (ba.rx_valid === 1'b1) begin
      ra_c.push_back(cyc);
      ra_d.push_back(ba.rx_data);
    end
    if (en_b === 1'b1) begin
      sb_c.push_back(cyc);
      sb_b.push_back(din_b);
    end
    if (bb.rx_valid === 1'b1) begin
      rb_c.push_back(cyc);
      rb_d.push_back(bb.rx_data);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reference: strobe k at acc+1+k*div carrying d MSB-first then
  // pad zeros; rx_valid at acc+2+(N-1)*div with rx_data == d.
  task automatic check_txn(input string nm,
                           input int sc[$], input logic sb[$],
                           input int rc[$], input logic [DW-1:0] rd[$],
                           input int acc, input int div,
                           input logic [DW-1:0] d,
                           input int nst, input bit exp_rx);
    int lo_c[$];
    logic lo_b[$];
    int n_rx;
    logic [DW-1:0] got_rx;
    int rx_at;
    int stop_c;
    stop_c = acc + 1 + (N - 1) * div;
    for (int i = 0; i < sc.size(); i++)
      if (sc[i] > acc && sc[i] <= stop_c) begin
        lo_c.push_back(sc[i]);
        lo_b.push_back(sb[i]);
      end
    chk({nm, ".n_stb"}, lo_c.size(), nst);
    for (int k = 0; k < nst && k < lo_c.size(); k++) begin
      chk({nm, ".stb_cyc"}, lo_c[k] - acc, 1 + k * div);
      chk({nm, ".stb_bit"}, lo_b[k], (k < DW) ? d[DW-1-k] : 1'b0);
    end
    n_rx = 0;
    got_rx = '0;
    rx_at = 0;
    for (int i = 0; i < rc.size(); i++)
      if (rc[i] > acc && rc[i] <= stop_c + 1) begin
        n_rx++;
        got_rx = rd[i];
        rx_at = rc[i];
      end
    chk({nm, ".n_rx"}, n_rx, exp_rx ? 1 : 0);
    if (exp_rx && n_rx == 1) begin
      chk({nm, ".rx_cyc"}, rx_at - acc, 2 + (N - 1) * div);
      chk({nm, ".rx_data"}, got_rx, d);
    end
  endtask

  task automatic send_a(input logic [DW-1:0] d, output int acc);
    int n;
    n = 0;
    while (ba.tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a.ready", ba.tx_ready, 1'b1);
    ba.tx_data  = d;
    ba.tx_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    ba.tx_valid = 1'b0;
    ba.tx_data  = DW'($urandom);
  endtask

  task automatic preload(input logic [CL-1:0] v);
    pre_val = v;
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  logic [DW-1:0] last_rx;

  task automatic run_a(input string nm, input logic [DW-1:0] d);
    int acc;
    send_a(d, acc);
    wait_to(acc + 2 + (N - 1) * 4 + 2);
    check_txn(nm, sa_c, sa_b, ra_c, ra_d, acc, 4, d, N, 1'b1);
    chk({nm, ".held"}, ba.rx_data, d);
    last_rx = d;
  endtask

  task automatic abort_a(input string nm, input logic [DW-1:0] d,
                         input int k);
    int acc;
    send_a(d, acc);
    wait_to(acc + 1 + k * 4);
    ba.abort = 1'b1;
    @(negedge clk);
    ba.abort = 1'b0;
    chk({nm, ".en"}, en_a, 1'b0);
    chk({nm, ".busy"}, ba.busy, 1'b0);
    chk({nm, ".ready"}, ba.tx_ready, 1'b1);
    wait_to(acc + 2 + (N - 1) * 4 + 2);
    check_txn(nm, sa_c, sa_b, ra_c, ra_d, acc, 4, d, k + 1, 1'b0);
    chk({nm, ".rx_kept"}, ba.rx_data, last_rx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, n, k;
    logic [DW-1:0] d;
    logic seen;
    last_rx = '0;
    ba.tx_data = '0; ba.tx_valid = 1'b0; ba.abort = 1'b0;
    bb.tx_data = '0; bb.tx_valid = 1'b0; bb.abort = 1'b0;
    pre_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.ready", ba.tx_ready, 1'b1);
    chk("rst.busy", ba.busy, 1'b0);
    chk("rst.en", en_a, 1'b0);
    rst_n = 1'b1;
    pre_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle.ready", ba.tx_ready, 1'b1);
    chk("idle.busy", ba.busy, 1'b0);
    chk("idle.en", en_a, 1'b0);
    chk("idle.din", din_a, 1'b0);
    chk("idle.rxv", ba.rx_valid, 1'b0);
    chk("idle.rxd", ba.rx_data, '0);
    chk("idle.n_stb", sa_c.size() + sb_c.size(), 0);

    run_a("loop_a5", 8'hA5);

    preload(3'b101);
    send_a(8'hFF, acc);
    wait_to(acc + 2 + (N - 1) * 4 + 2);
    check_txn("stale", sa_c, sa_b, ra_c, ra_d, acc, 4, 8'hFF, N, 1'b1);
    n = sa_c.size() - N;
    chk("stale.o0", sa_o[n], 1'b1);
    chk("stale.o1", sa_o[n+1], 1'b0);
    chk("stale.o2", sa_o[n+2], 1'b1);
    last_rx = 8'hFF;

    send_a(8'hA5, acc);
    wait_to(acc + 10);
    ba.tx_data = 8'h00;
    ba.tx_valid = 1'b1;
    @(negedge clk);
    ba.tx_valid = 1'b0;
    wait_to(acc + 2 + (N - 1) * 4 + 2);
    check_txn("ign", sa_c, sa_b, ra_c, ra_d, acc, 4, 8'hA5, N, 1'b1);
    chk("ign.held", ba.rx_data, 8'hA5);
    last_rx = 8'hA5;

    abort_a("abt5", 8'h5A, 5);
    abort_a("abt_last", 8'h96, N - 1);
    abort_a("abt0", 8'h81, 0);

    ba.tx_data = 8'h77;
    ba.tx_valid = 1'b1;
    ba.abort = 1'b1;
    @(negedge clk);
    ba.tx_valid = 1'b0;
    ba.abort = 1'b0;
    chk("idle_abt.busy", ba.busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_abt.en", en_a, 1'b0);

    preload('0);
    bb.tx_data = 8'h3C;
    bb.tx_valid = 1'b1;
    acc = cyc;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bb.rx_valid === 1'b1) seen = 1'b1;
    end
    chk("b2b.first_rx", seen, 1'b1);
    bb.tx_data = 8'hC3;
    acc2 = cyc;
    @(negedge clk);
    bb.tx_valid = 1'b0;
    wait_to(acc2 + 2 + (N - 1) + 3);
    chk("b2b.gap", acc2 - acc, 2 + (N - 1));
    check_txn("b2b1", sb_c, sb_b, rb_c, rb_d, acc, 1, 8'h3C, N, 1'b1);
    check_txn("b2b2", sb_c, sb_b, rb_c, rb_d, acc2, 1, 8'hC3, N, 1'b1);

    for (int i = 0; i < 8; i++) begin
      preload(CL'($urandom));
      d = DW'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, N - 1);
        abort_a("rnd_abt", d, k);
      end else begin
        run_a("rnd", d);
      end
    end

    send_a(DW'($urandom), acc);
    wait_to(acc + 15);
    rst_n = 1'b0;
    #1;
    chk("mrst.en", en_a, 1'b0);
    chk("mrst.busy", ba.busy, 1'b0);
    chk("mrst.ready", ba.tx_ready, 1'b1);
    chk("mrst.rxd", ba.rx_data, '0);
    chk("mrst.din", din_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n = sa_c.size();
    repeat (60) @(negedge clk);
    k = 0;
    for (int i = 0; i < ra_c.size(); i++)
      if (ra_c[i] > acc) k++;
    chk("mrst.n_rx", k, 0);
    chk("mrst.n_stb", sa_c.size() - n, 0);
    chk("mrst.busy2", ba.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
